// File: rtl/fetch_buffer.sv
// Instruction fetch queue: halfword ring buffer with one outstanding memory request.
// Compressed (16-bit) instruction support is enabled by defining FETCH_BUF_RVC_EN.
module fetch_buffer #(
  parameter int unsigned    AW       = 32,
  parameter int unsigned    DW       = 32,
  parameter int unsigned    HW_DEPTH = 8,
  parameter logic [AW-1:0]  RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic          instr_valid,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  input  logic          instr_ready
);

  localparam int unsigned PW = $clog2(HW_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

  state_e        r_state;
  logic [15:0]   r_buf [HW_DEPTH];
  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_wptr;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_fetch_addr;
  logic [AW-1:0] r_pc;
  logic          r_skip_lo;

  logic [15:0]   w_head_lo;
  logic [15:0]   w_head_hi;
  logic          w_is32;
  logic          w_pop;
  logic          w_push;
  logic [CW-1:0] w_need;
  logic [CW-1:0] w_free;
  logic [CW-1:0] w_push_hw;
  logic [CW-1:0] w_pop_hw;
  logic [AW-1:0] w_redir_pc;
  logic          w_redir_skip;
  logic [31:0]   w_instr32;

  // Head slot plus its successor; the pointer wraps so split instructions assemble naturally.
  assign w_head_lo = r_buf[r_rptr];
  assign w_head_hi = r_buf[r_rptr + PW'(1)];

`ifdef FETCH_BUF_RVC_EN
  assign w_is32       = (w_head_lo[1:0] == 2'b11);
  assign w_redir_pc   = redirect_pc;
  assign w_redir_skip = redirect_pc[1];
`else
  logic [1:0] w_unused_pc_lsb;
  assign w_is32          = 1'b1;
  assign w_redir_pc      = {redirect_pc[AW-1:2], 2'b00};
  assign w_redir_skip    = 1'b0;
  assign w_unused_pc_lsb = redirect_pc[1:0];
`endif

  assign w_need      = w_is32 ? CW'(2) : CW'(1);
  assign w_free      = CW'(HW_DEPTH) - r_count;
  assign instr_valid = (r_count >= w_need);
  assign w_instr32   = w_is32 ? {w_head_hi, w_head_lo} : {16'h0000, w_head_lo};
  assign instr       = DW'(w_instr32);
  assign instr_pc    = r_pc;
  assign mem_addr    = r_fetch_addr;

  assign w_pop     = instr_valid && instr_ready;
  assign w_push    = (r_state == StWait) && mem_rvalid;
  assign w_push_hw = w_push ? (r_skip_lo ? CW'(1) : CW'(2)) : '0;
  assign w_pop_hw  = w_pop ? w_need : '0;

  // Two free slots guarantee the response always fits, even with no pop in between.
  assign mem_req = (r_state == StIdle) && (w_free >= CW'(2)) && !redirect && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_rptr       <= '0;
      r_wptr       <= '0;
      r_count      <= '0;
      r_fetch_addr <= RESET_PC;
      r_pc         <= RESET_PC;
      r_skip_lo    <= 1'b0;
    end else if (redirect) begin
      // An in-flight response that has not yet arrived must be swallowed later.
      r_state      <= (r_state != StIdle && !mem_rvalid) ? StDrop : StIdle;
      r_rptr       <= '0;
      r_wptr       <= '0;
      r_count      <= '0;
      r_pc         <= w_redir_pc;
      r_fetch_addr <= {redirect_pc[AW-1:2], 2'b00};
      r_skip_lo    <= w_redir_skip;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (mem_req) begin
            r_state      <= StWait;
            r_fetch_addr <= r_fetch_addr + AW'(4);
          end
        end
        StWait, StDrop: begin
          if (mem_rvalid) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase

      if (w_push) begin
        if (r_skip_lo) begin
          r_buf[r_wptr] <= mem_rdata[31:16];
        end else begin
          r_buf[r_wptr]          <= mem_rdata[15:0];
          r_buf[r_wptr + PW'(1)] <= mem_rdata[31:16];
        end
        r_skip_lo <= 1'b0;
      end

      if (w_pop) r_pc <= r_pc + (w_is32 ? AW'(4) : AW'(2));

      r_rptr  <= r_rptr + w_pop_hw[PW-1:0];
      r_wptr  <= r_wptr + w_push_hw[PW-1:0];
      r_count <= r_count + w_push_hw - w_pop_hw;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: a memory responder with variable latency and an in-order
// instruction-stream model derived from the memory image and the current PC.
module tb_fetch_buffer;

  localparam int unsigned AW       = 32;
  localparam int unsigned DW       = 32;
  localparam int unsigned HW_DEPTH = 8;
  localparam logic [31:0] RESET_PC = 32'h0;
`ifdef FETCH_BUF_RVC_EN
  localparam bit RVC = 1'b1;
`else
  localparam bit RVC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          instr_valid;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_ready = 1'b0;

  fetch_buffer #(
    .AW(AW), .DW(DW), .HW_DEPTH(HW_DEPTH), .RESET_PC(RESET_PC)
  ) u_dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  logic [31:0] img [256];
  int n_checks = 0;
  int n_errors = 0;

  // memory responder state
  bit          pend = 1'b0;
  logic [31:0] pend_addr;
  int          pend_cnt;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          keep_stale = 1'b0;
  int          resp_cnt = 0;

  // reference model and bookkeeping
  logic [31:0] m_pc = RESET_PC;
  int          pops = 0;
  logic [31:0] log_pc [4];
  logic [31:0] log_instr [4];
  int          n_log = 0;
  bit          req_seen = 1'b0;
  logic [31:0] req_addr;
  bit          prev_hold = 1'b0;
  logic [31:0] hold_instr;
  logic [31:0] hold_pc;
  bit          prev_redir = 1'b0;
  bit          prev_rst = 1'b0;
  int          stall = 0;
  int          max_stall = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] hw_at(input logic [31:0] a);
    logic [31:0] w;
    w = img[a[9:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // Instruction at pc as the architecture defines it, independent of buffering.
  function automatic logic [31:0] ref_instr(input logic [31:0] pc, output int size);
    logic [15:0] h0;
    h0 = hw_at(pc);
    if (RVC && h0[1:0] != 2'b11) begin
      size = 2;
      return {16'h0000, h0};
    end
    size = 4;
    return {hw_at(pc + 32'd2), h0};
  endfunction

  task automatic tick();
    logic [31:0] e_instr;
    int          sz;
    @(negedge clk);
    if (prev_redir && !rst) begin
      check_eq("redir_flush_valid", instr_valid, 1'b0);
      check_eq("redir_instr_pc", instr_pc, m_pc);
    end
    if (prev_rst && !rst) begin
      check_eq("rst_valid", instr_valid, 1'b0);
      check_eq("rst_instr_pc", instr_pc, RESET_PC);
      if (!redirect) begin
        check_eq("rst_mem_req", mem_req, 1'b1);
        check_eq("rst_mem_addr", mem_addr, RESET_PC);
      end
    end
    if (prev_hold && !rst) begin
      check_eq("hold_valid", instr_valid, 1'b1);
      check_eq("hold_instr", instr, hold_instr);
      check_eq("hold_pc", instr_pc, hold_pc);
    end
    if (rst) begin
      m_pc = RESET_PC;
    end else if (redirect) begin
      m_pc = RVC ? redirect_pc : (redirect_pc & ~32'h3);
    end else if (instr_valid && instr_ready) begin
      e_instr = ref_instr(m_pc, sz);
      check_eq("pop_pc", instr_pc, m_pc);
      check_eq("pop_instr", instr, e_instr);
      if (n_log < 4) begin
        log_pc[n_log]    = instr_pc;
        log_instr[n_log] = instr;
        n_log++;
      end
      m_pc = m_pc + sz;
      pops++;
    end
    if (!rst && !redirect && instr_ready && !instr_valid) stall++;
    else stall = 0;
    if (stall > max_stall) max_stall = stall;
    if (rst && !keep_stale) pend = 1'b0;
    if (mem_req) begin
      check_eq("one_outstanding", pend, 1'b0);
      check_eq("addr_aligned", mem_addr[1:0], 2'b00);
      pend      = 1'b1;
      pend_addr = mem_addr;
      pend_cnt  = $urandom_range(lat_max, lat_min);
      req_seen  = 1'b1;
      req_addr  = mem_addr;
    end
    prev_hold  = !rst && !redirect && instr_valid && !instr_ready;
    hold_instr = instr;
    hold_pc    = instr_pc;
    prev_redir = redirect && !rst;
    prev_rst   = rst;
    @(posedge clk);
    #1;
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = img[pend_addr[9:2]];
        pend       = 1'b0;
        resp_cnt++;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    redirect = 1'b0;
    run(2);
    rst       = 1'b0;
    pops      = 0;
    n_log     = 0;
    resp_cnt  = 0;
    req_seen  = 1'b0;
    max_stall = 0;
  endtask

  task automatic wait_req(input int limit);
    for (int i = 0; i < limit && !req_seen; i++) tick();
    check_eq("req_timeout", req_seen, 1'b1);
  endtask

  task automatic fill_img(input bit rnd, input logic [31:0] val);
    for (int i = 0; i < 256; i++) img[i] = rnd ? $urandom : val;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Steady stream of 0x13 words at one-cycle latency.
    fill_img(1'b0, 32'h0000_0013);
    lat_min = 1; lat_max = 1;
    instr_ready = 1'b1;
    do_reset();
    run(40);
    check_eq("nop_first_pc", log_pc[0], 32'h0);
    check_eq("nop_first_instr", log_instr[0], 32'h13);
    check_eq("nop_second_pc", log_pc[1], 32'h4);
    check_eq("nop_third_pc", log_pc[2], 32'h8);
    check_eq("nop_progress", pops >= 10, 1'b1);

    // Two compressed instructions packed in one word.
    img[0] = 32'h4501_4501;
    do_reset();
    run(20);
    check_eq("c_li_first_pc", log_pc[0], 32'h0);
    check_eq("c_li_first", log_instr[0], RVC ? 32'h0000_4501 : 32'h4501_4501);
    check_eq("c_li_second_pc", log_pc[1], RVC ? 32'h2 : 32'h4);

    // 32-bit instruction split across two memory words.
    img[0] = 32'h0013_4501;
    img[1] = 32'hABCD_0000;
    do_reset();
    run(20);
    check_eq("split_first", log_instr[0], RVC ? 32'h0000_4501 : 32'h0013_4501);
    check_eq("split_second_pc", log_pc[1], RVC ? 32'h2 : 32'h4);
    check_eq("split_second", log_instr[1], RVC ? 32'h0000_0013 : 32'hABCD_0000);

    // Redirect while waiting; the stale response lands in the next cycle.
    fill_img(1'b1, 32'h0);
    lat_min = 2; lat_max = 2;
    do_reset();
    wait_req(5);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0102;
    req_seen    = 1'b0;
    n_log       = 0;
    tick();
    redirect = 1'b0;
    wait_req(10);
    check_eq("redir_mem_addr", req_addr, 32'h100);
    run(30);
    check_eq("redir_first_pc", log_pc[0], RVC ? 32'h102 : 32'h100);

    // Consumer stalls: the buffer fills and fetching stops without losing data.
    lat_min = 1; lat_max = 1;
    instr_ready = 1'b0;
    do_reset();
    run(15);
    req_seen = 1'b0;
    run(5);
    check_eq("stall_no_req", req_seen, 1'b0);
    check_eq("stall_fill_hw", resp_cnt * 2, HW_DEPTH);
    instr_ready = 1'b1;
    run(40);
    check_eq("stall_resume_pc", log_pc[0], RESET_PC);
    check_eq("stall_resume_progress", pops >= 8, 1'b1);

    // Reset in the middle of a wait with the stale response arriving just after.
    lat_min = 2; lat_max = 2;
    do_reset();
    keep_stale = 1'b1;
    req_seen   = 1'b0;
    wait_req(5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    keep_stale = 1'b0;
    req_seen = 1'b0;
    n_log = 0;
    tick();
    check_eq("rst_stale_dropped", instr_valid, 1'b0);
    check_eq("rst_stale_addr", req_addr, RESET_PC);
    run(30);
    check_eq("rst_stale_first_pc", log_pc[0], RESET_PC);

    // Randomised traffic: latency, back-pressure and redirects.
    fill_img(1'b1, 32'h0);
    lat_min = 1; lat_max = 3;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      instr_ready = ($urandom_range(0, 9) < 7);
      redirect    = ($urandom_range(0, 29) == 0);
      redirect_pc = {21'h0, 10'($urandom_range(0, 511)), 1'b0};
      tick();
    end
    redirect = 1'b0;
    run(10);
    check_eq("rand_liveness", max_stall < 30, 1'b1);
    check_eq("rand_progress", pops > 100, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
